mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 119 +++++++++++
 tb/tb_mem_io_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Memory-mapped responder: byte RAM below 0x30000, TX/RX byte FIFOs behind
// a data port at 0x30000 and a status port at 0x30004.
module mem_io_responder #(
    parameter int RAM_ADDR_W   = 17,
    parameter int TX_DEPTH_LOG = 3,
    parameter int RX_DEPTH_LOG = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
    localparam logic [17:0] DATA_ADDR = 18'h30000;
    localparam logic [17:0] STAT_ADDR = 18'h30004;
    localparam logic [TX_DEPTH_LOG:0] TX_PTR_ONE = {{TX_DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [RX_DEPTH_LOG:0] RX_PTR_ONE = {{RX_DEPTH_LOG{1'b0}}, 1'b1};

    logic [7:0] ram    [0:(1 << RAM_ADDR_W)-1];
    logic [7:0] tx_mem [0:TX_DEPTH-1];
    logic [7:0] rx_mem [0:RX_DEPTH-1];

    logic [TX_DEPTH_LOG:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RX_DEPTH_LOG:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic                  rx_ovf_q, rx_ovf_d;
    logic [7:0]            io_din_q, io_din_d;
    logic                  ram_rd_sel_q, ram_rd_sel_d;
    logic [7:0]            ram_rd_q;

    logic                  ram_sel, data_sel, stat_sel;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  tx_full, tx_push, tx_pop;
    logic                  rx_full, rx_nonempty, rx_push, rx_pop;
    logic                  unused_addr_bits;

    assign ram_sel  = (cpu_a[17:16] != 2'b11);
    assign data_sel = (cpu_a[17:0] == DATA_ADDR);
    assign stat_sel = (cpu_a[17:0] == STAT_ADDR);
    assign ram_addr = cpu_a[RAM_ADDR_W-1:0];
    assign unused_addr_bits = ^cpu_a[31:18];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign tx_full = (tx_wr_q[TX_DEPTH_LOG] != tx_rd_q[TX_DEPTH_LOG]) &&
                     (tx_wr_q[TX_DEPTH_LOG-1:0] == tx_rd_q[TX_DEPTH_LOG-1:0]);
    assign rx_full = (rx_wr_q[RX_DEPTH_LOG] != rx_rd_q[RX_DEPTH_LOG]) &&
                     (rx_wr_q[RX_DEPTH_LOG-1:0] == rx_rd_q[RX_DEPTH_LOG-1:0]);
    assign rx_nonempty    = (rx_wr_q != rx_rd_q);
    assign io_buffer_full = tx_full;
    assign tx_valid       = (tx_wr_q != tx_rd_q);
    assign tx_data        = tx_mem[tx_rd_q[TX_DEPTH_LOG-1:0]];

    assign tx_push = cpu_wr && data_sel && !tx_full;
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_push = rx_valid && !rx_full;
    assign rx_pop  = !cpu_wr && data_sel && rx_nonempty;

    // RAM reads come from a separate unreset register so the array maps to block RAM.
    assign cpu_din = ram_rd_sel_q ? ram_rd_q : io_din_q;

    always_comb begin
        tx_wr_d      = tx_wr_q;
        tx_rd_d      = tx_rd_q;
        rx_wr_d      = rx_wr_q;
        rx_rd_d      = rx_rd_q;
        rx_ovf_d     = rx_ovf_q;
        io_din_d     = 8'h00;
        ram_rd_sel_d = !cpu_wr && ram_sel;
        if (tx_push) tx_wr_d = tx_wr_q + TX_PTR_ONE;
        if (tx_pop)  tx_rd_d = tx_rd_q + TX_PTR_ONE;
        if (rx_push) rx_wr_d = rx_wr_q + RX_PTR_ONE;
        if (rx_pop)  rx_rd_d = rx_rd_q + RX_PTR_ONE;
        if (cpu_wr && stat_sel) rx_ovf_d = 1'b0;
        if (rx_valid && rx_full) rx_ovf_d = 1'b1;
        if (!cpu_wr) begin
            if (rx_pop) begin
                io_din_d = rx_mem[rx_rd_q[RX_DEPTH_LOG-1:0]];
            end else if (stat_sel) begin
                io_din_d = {5'b0, rx_ovf_q, tx_full, rx_nonempty};
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_ovf_q     <= 1'b0;
            io_din_q     <= 8'h00;
            ram_rd_sel_q <= 1'b0;
        end else begin
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            rx_ovf_q     <= rx_ovf_d;
            io_din_q     <= io_din_d;
            ram_rd_sel_q <= ram_rd_sel_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (cpu_wr && ram_sel) ram[ram_addr] <= cpu_dout;
        ram_rd_q <= ram[ram_addr];
        if (tx_push) tx_mem[tx_wr_q[TX_DEPTH_LOG-1:0]] <= cpu_dout;
        if (rx_push) rx_mem[rx_wr_q[RX_DEPTH_LOG-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a vector table for the RAM, TX and RX
// paths plus a hand-written asynchronous reset sequence.
module tb_mem_io_responder;

    localparam logic [31:0] DATA = 32'h0003_0000;
    localparam logic [31:0] STAT = 32'h0003_0004;
    localparam logic [31:0] IDLE = 32'h0003_000C;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  dout;
        logic        txReady;
        logic        rxValid;
        logic [7:0]  rxData;
        logic [7:0]  expDin;
        logic        expFull;
        logic        expValid;
        logic [7:0]  expTx;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int   testsRun = 0;
    int   testsFailed = 0;
    vec_t vecs[$];

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk_in = ~clk_in;

    function automatic void addVec(logic wr, logic [31:0] addr, logic [7:0] dout,
                                   logic txReady, logic rxValid, logic [7:0] rxData,
                                   logic [7:0] expDin, logic expFull, logic expValid,
                                   logic [7:0] expTx);
        vec_t v;
        v.wr = wr; v.addr = addr; v.dout = dout; v.txReady = txReady;
        v.rxValid = rxValid; v.rxData = rxData; v.expDin = expDin;
        v.expFull = expFull; v.expValid = expValid; v.expTx = expTx;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [7:0] act, input logic [7:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s (step %0d): got 0x%02h, expected 0x%02h", name, idx, act, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge happen, then sample just after it.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [7:0] dout,
                                 input logic txReady, input logic rxValid, input logic [7:0] rxData);
        @(negedge clk_in);
        cpu_wr = wr; cpu_a = addr; cpu_dout = dout;
        tx_ready = txReady; rx_valid = rxValid; rx_data = rxData;
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkAll(input int idx, input logic [7:0] expDin, input logic expFull,
                            input logic expValid, input logic [7:0] expTx);
        checkOutput("cpu_din", idx, cpu_din, expDin);
        checkOutput("io_buffer_full", idx, {7'b0, io_buffer_full}, {7'b0, expFull});
        checkOutput("tx_valid", idx, {7'b0, tx_valid}, {7'b0, expValid});
        if (expValid) checkOutput("tx_data", idx, tx_data, expTx);
    endtask

    initial begin
        // RAM round trip
        addVec(1'b1, 32'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b1, 32'h11, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, 32'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, 32'h11, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 8'h00);
        // TX fill to full, overfill dropped, status shows full, then drain
        for (int k = 1; k <= 8; k++)
            addVec(1'b1, DATA, 8'(k), 1'b0, 1'b0, 8'h00, 8'h00, k == 8, 1'b1, 8'h01);
        addVec(1'b1, DATA, 8'h09, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01);
        addVec(1'b0, STAT, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1, 8'h01);
        for (int i = 1; i <= 8; i++)
            addVec(1'b0, IDLE, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, i < 8, 8'(1 + i));
        // TX full with simultaneous push and pop
        for (int k = 1; k <= 8; k++)
            addVec(1'b1, DATA, 8'(32 + k), 1'b0, 1'b0, 8'h00, 8'h00, k == 8, 1'b1, 8'h21);
        addVec(1'b1, DATA, 8'h09, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h22);
        for (int i = 1; i <= 7; i++)
            addVec(1'b0, IDLE, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, i < 7, 8'(34 + i));
        // RX path, including push at empty concurrent with a data read
        addVec(1'b0, IDLE, 8'h00, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, STAT, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, IDLE, 8'h00, 1'b0, 1'b1, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, DATA, 8'h00, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, DATA, 8'h00, 1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, DATA, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, DATA, 8'h00, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, DATA, 8'h00, 1'b0, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0, 8'h00);
        // RX overflow, clear, then pop at full with a concurrent push
        for (int k = 1; k <= 9; k++)
            addVec(1'b0, IDLE, 8'h00, 1'b0, 1'b1, 8'(64 + k), 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, STAT, 8'h00, 1'b0, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0, 8'h00);
        addVec(1'b1, STAT, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, STAT, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, DATA, 8'h00, 1'b0, 1'b1, 8'h99, 8'h41, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, STAT, 8'h00, 1'b0, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0, 8'h00);
        for (int k = 2; k <= 8; k++)
            addVec(1'b0, DATA, 8'h00, 1'b0, 1'b0, 8'h00, 8'(64 + k), 1'b0, 1'b0, 8'h00);
        addVec(1'b0, DATA, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, STAT, 8'h00, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 8'h00);
        addVec(1'b1, STAT, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, STAT, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        // Reset state while rst_in is held low
        #12;
        checkAll(-1, 8'h00, 1'b0, 1'b0, 8'h00);
        @(negedge clk_in);
        rst_in = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].dout,
                          vecs[i].txReady, vecs[i].rxValid, vecs[i].rxData);
            checkAll(i, vecs[i].expDin, vecs[i].expFull, vecs[i].expValid, vecs[i].expTx);
        end

        // Load 3 TX and 2 RX entries and leave a nonzero byte on cpu_din
        applyStimulus(1'b1, DATA, 8'h51, 1'b0, 1'b1, 8'h61);
        checkAll(1000, 8'h00, 1'b0, 1'b1, 8'h51);
        applyStimulus(1'b1, DATA, 8'h52, 1'b0, 1'b1, 8'h62);
        applyStimulus(1'b1, DATA, 8'h53, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 32'h10, 8'h00, 1'b0, 1'b0, 8'h00);
        checkAll(1001, 8'hA5, 1'b0, 1'b1, 8'h51);

        // Assert reset between edges: outputs must clear without a clock edge
        #2;
        rst_in = 1'b0;
        #1;
        checkAll(1002, 8'h00, 1'b0, 1'b0, 8'h00);

        // A data-port write across an edge while in reset must not land in the FIFO
        @(negedge clk_in);
        cpu_wr = 1'b1; cpu_a = DATA; cpu_dout = 8'h77; rx_valid = 1'b0;
        @(posedge clk_in);
        #1;
        checkAll(1003, 8'h00, 1'b0, 1'b0, 8'h00);

        // Release and read status on the first active edge
        @(negedge clk_in);
        rst_in = 1'b1;
        cpu_wr = 1'b0; cpu_a = STAT; cpu_dout = 8'h00;
        @(posedge clk_in);
        #1;
        checkAll(1004, 8'h00, 1'b0, 1'b0, 8'h00);

        // RAM keeps its contents through reset
        applyStimulus(1'b0, 32'h11, 8'h00, 1'b0, 1'b0, 8'h00);
        checkAll(1005, 8'h3C, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
